// File: rtl/dds_pkg.sv
// Definitions shared by the DDS sweep sequencer and the DDS wave generator.
// Word widths here must match the generator's K/P inputs.
package dds_pkg;

  localparam int K_W = 32;
  localparam int P_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host-side control/configuration bus plus the DDS-facing outputs of the sweep sequencer.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int IDX_W   = 16
) ();

  logic               start;
  logic               abort;
  logic [K_W-1:0]     cfg_start_k;
  logic [K_W-1:0]     cfg_stop_k;
  logic [K_W-1:0]     cfg_step_k;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [P_W-1:0]     cfg_phase;
  logic               cfg_repeat;

  logic [K_W-1:0]     k_out;
  logic [P_W-1:0]     p_out;
  logic               k_valid;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   step_idx;

  modport master (
    output start, abort, cfg_start_k, cfg_stop_k, cfg_step_k,
           cfg_dwell, cfg_phase, cfg_repeat,
    input  k_out, p_out, k_valid, busy, done, step_idx
  );

  modport slave (
    input  start, abort, cfg_start_k, cfg_stop_k, cfg_step_k,
           cfg_dwell, cfg_phase, cfg_repeat,
    output k_out, p_out, k_valid, busy, done, step_idx
  );

endinterface

// File: rtl/dds_step_calc.sv
// Combinational next-frequency-word calculation: one signed step toward the stop word,
// clamped to the stop word on overshoot or on 32-bit wrap in either direction.
module dds_step_calc
  import dds_pkg::*;
(
  input  logic [K_W-1:0] cur_k,
  input  logic [K_W-1:0] step_k,
  input  logic [K_W-1:0] stop_k,
  input  logic           dir_up,
  output logic [K_W-1:0] next_k,
  output logic           at_stop
);

  logic [K_W:0] sum_ext;
  logic [K_W:0] diff_ext;
  logic         up_clamp;
  logic         down_clamp;

  // Bit K_W of the extended result is the carry (up) or borrow (down).
  assign sum_ext  = {1'b0, cur_k} + {1'b0, step_k};
  assign diff_ext = {1'b0, cur_k} - {1'b0, step_k};

  assign up_clamp   = sum_ext[K_W]  || (sum_ext[K_W-1:0]  > stop_k);
  assign down_clamp = diff_ext[K_W] || (diff_ext[K_W-1:0] < stop_k);

  always_comb begin
    next_k = stop_k;
    if (dir_up) begin
      if (!up_clamp) begin
        next_k = sum_ext[K_W-1:0];
      end
    end else begin
      if (!down_clamp) begin
        next_k = diff_ext[K_W-1:0];
      end
    end
  end

  // A zero step can never advance, so it is treated as a single-point sweep.
  assign at_stop = (cur_k == stop_k) || (step_k == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer for the DDS: steps K from start to stop, holding
// each point for dwell+1 cycles, with optional repeat and abort.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int IDX_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  dds_sweep_ctrl_if.slave bus
);

  sweep_state_t       state_reg, state_next;

  logic [K_W-1:0]     start_k_reg, start_k_next;
  logic [K_W-1:0]     stop_k_reg, stop_k_next;
  logic [K_W-1:0]     step_k_reg, step_k_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               repeat_reg, repeat_next;
  logic               dir_up_reg, dir_up_next;

  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [K_W-1:0]     k_reg, k_next;
  logic [P_W-1:0]     p_reg, p_next;
  logic               k_valid_reg, k_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;

  logic [K_W-1:0]     calc_next_k;
  logic               calc_at_stop;

  dds_step_calc u_step_calc (
    .cur_k   (k_reg),
    .step_k  (step_k_reg),
    .stop_k  (stop_k_reg),
    .dir_up  (dir_up_reg),
    .next_k  (calc_next_k),
    .at_stop (calc_at_stop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_k_reg <= '0;
      stop_k_reg  <= '0;
      step_k_reg  <= '0;
      dwell_reg   <= '0;
      repeat_reg  <= 1'b0;
      dir_up_reg  <= 1'b0;
      cnt_reg     <= '0;
      k_reg       <= '0;
      p_reg       <= '0;
      k_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      start_k_reg <= start_k_next;
      stop_k_reg  <= stop_k_next;
      step_k_reg  <= step_k_next;
      dwell_reg   <= dwell_next;
      repeat_reg  <= repeat_next;
      dir_up_reg  <= dir_up_next;
      cnt_reg     <= cnt_next;
      k_reg       <= k_next;
      p_reg       <= p_next;
      k_valid_reg <= k_valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      idx_reg     <= idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_k_next = start_k_reg;
    stop_k_next  = stop_k_reg;
    step_k_next  = step_k_reg;
    dwell_next   = dwell_reg;
    repeat_next  = repeat_reg;
    dir_up_next  = dir_up_reg;
    cnt_next     = cnt_reg;
    k_next       = k_reg;
    p_next       = p_reg;
    k_valid_next = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    idx_next     = idx_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          start_k_next = bus.cfg_start_k;
          stop_k_next  = bus.cfg_stop_k;
          step_k_next  = bus.cfg_step_k;
          dwell_next   = bus.cfg_dwell;
          repeat_next  = bus.cfg_repeat;
          dir_up_next  = (bus.cfg_stop_k >= bus.cfg_start_k);
          k_next       = bus.cfg_start_k;
          p_next       = bus.cfg_phase;
          k_valid_next = 1'b1;
          busy_next    = 1'b1;
          idx_next     = '0;
          cnt_next     = bus.cfg_dwell;
          state_next   = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DWELL_W'(1);
        end else if (!calc_at_stop) begin
          k_next       = calc_next_k;
          k_valid_next = 1'b1;
          idx_next     = (&idx_reg) ? idx_reg : idx_reg + IDX_W'(1);
          cnt_next     = dwell_reg;
        end else if (repeat_reg) begin
          // Restart from the shadowed start word; live cfg is not re-sampled.
          k_next       = start_k_reg;
          k_valid_next = 1'b1;
          idx_next     = '0;
          cnt_next     = dwell_reg;
        end else begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.k_out    = k_reg;
  assign bus.p_out    = p_reg;
  assign bus.k_valid  = k_valid_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.step_idx = idx_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand-written corner
// sequences, and random sweeps checked against a point-list model.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.DWELL_W(16), .IDX_W(16)) bus ();

  dds_sweep_ctrl #(.DWELL_W(16), .IDX_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  string       cur_tag;
  int          cur_c;
  logic [31:0] exp_q[$];
  int          exp_done;

  typedef struct {
    logic [31:0] start_k;
    logic [31:0] stop_k;
    logic [31:0] step_k;
    int          dwell;
    int          n;
    logic [31:0] k[4];
    int          done_c;
    int          inject;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cycle=%0d: got 0x%0h expected 0x%0h", cur_tag, name, cur_c, act, exp);
    end
  endtask

  // Reference: the list of frequency points a sweep visits, by plain 64-bit arithmetic.
  function automatic void build_points(input logic [31:0] s, input logic [31:0] e,
                                       input logic [31:0] st);
    longint p, nx;
    exp_q.delete();
    exp_q.push_back(s);
    if (st == 0 || s == e) return;
    p = longint'(s);
    for (int g = 0; g < 100000; g++) begin
      if (e > s) begin
        nx = p + longint'(st);
        if (nx >= longint'(e)) begin exp_q.push_back(e); return; end
      end else begin
        nx = p - longint'(st);
        if (nx <= longint'(e)) begin exp_q.push_back(e); return; end
      end
      exp_q.push_back(nx[31:0]);
      p = nx;
    end
  endfunction

  task automatic set_vec(input int i, input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] st, input int d, input int n,
                         input logic [31:0] k0, input logic [31:0] k1,
                         input logic [31:0] k2, input logic [31:0] k3,
                         input int done_c, input int inject);
    vecs[i].start_k = s;  vecs[i].stop_k = e;  vecs[i].step_k = st;
    vecs[i].dwell   = d;  vecs[i].n      = n;
    vecs[i].k[0] = k0; vecs[i].k[1] = k1; vecs[i].k[2] = k2; vecs[i].k[3] = k3;
    vecs[i].done_c = done_c;
    vecs[i].inject = inject;
  endtask

  // Runs one non-repeating sweep; expects exp_q / exp_done to be set by the caller.
  task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input int d, input logic [10:0] ph,
                           input int inject);
    int n;
    int idx;
    bit kv;
    n = exp_q.size();
    cur_tag = tag;
    @(posedge clk); #1;
    bus.cfg_start_k = s;
    bus.cfg_stop_k  = e;
    bus.cfg_step_k  = st;
    bus.cfg_dwell   = 16'(d);
    bus.cfg_phase   = ph;
    bus.cfg_repeat  = 1'b0;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (inject != 0 && c == inject) begin
        bus.start      = 1'b1;
        bus.cfg_stop_k = e ^ 32'h0000_0F00;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cur_c = c;
      idx = (c - 1) / (d + 1);
      if (idx > n - 1) idx = n - 1;
      kv = (c < exp_done) && (((c - 1) % (d + 1)) == 0);
      chk("k_out",    bus.k_out,    exp_q[idx]);
      chk("p_out",    bus.p_out,    ph);
      chk("k_valid",  bus.k_valid,  kv);
      chk("busy",     bus.busy,     c < exp_done);
      chk("done",     bus.done,     c == exp_done);
      chk("step_idx", bus.step_idx, idx);
    end
    bus.start = 1'b0;
    $display("sweep %s: start=0x%08h stop=0x%08h step=0x%0h dwell=%0d points=%0d done_cycle=%0d",
             tag, s, e, st, d, n, exp_done);
  endtask

  initial begin
    logic [31:0] rs, re, rst_k;
    longint      el;
    int          rd, span;

    rst = 1'b1;
    bus.start = 1'b0;       bus.abort = 1'b0;
    bus.cfg_start_k = '0;   bus.cfg_stop_k = '0;  bus.cfg_step_k = '0;
    bus.cfg_dwell = '0;     bus.cfg_phase = '0;   bus.cfg_repeat = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    cur_tag = "reset"; cur_c = 0;
    chk("k_out", bus.k_out, 0);       chk("p_out", bus.p_out, 0);
    chk("k_valid", bus.k_valid, 0);   chk("busy", bus.busy, 0);
    chk("done", bus.done, 0);         chk("step_idx", bus.step_idx, 0);
    $display("reset: outputs checked");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table
    set_vec(0, 32'd100, 32'd130, 32'd10, 2, 4, 32'd100, 32'd110, 32'd120, 32'd130, 13, 0);
    set_vec(1, 32'd0,   32'd25,  32'd10, 0, 4, 32'd0,   32'd10,  32'd20,  32'd25,  5,  0);
    set_vec(2, 32'd50,  32'd20,  32'd15, 1, 3, 32'd50,  32'd35,  32'd20,  32'd0,   7,  0);
    set_vec(3, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 2,
            32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 3, 0);
    set_vec(4, 32'h10,  32'h0,   32'h20, 0, 2, 32'h10,  32'h0,   32'd0,   32'd0,   3,  0);
    set_vec(5, 32'd5,   32'd100, 32'd0,  3, 1, 32'd5,   32'd0,   32'd0,   32'd0,   5,  0);
    set_vec(6, 32'd7,   32'd7,   32'd3,  1, 1, 32'd7,   32'd0,   32'd0,   32'd0,   3,  0);
    set_vec(7, 32'd100, 32'd130, 32'd10, 2, 4, 32'd100, 32'd110, 32'd120, 32'd130, 13, 4);

    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].k[j]);
      exp_done = vecs[i].done_c;
      run_sweep($sformatf("vec%0d", i), vecs[i].start_k, vecs[i].stop_k, vecs[i].step_k,
                vecs[i].dwell, 11'(i * 37 + 1), vecs[i].inject);
    end

    // Repeating sweep 10,20,30,... with abort in cycle 7
    cur_tag = "repeat_abort";
    @(posedge clk); #1;
    bus.cfg_start_k = 32'd10; bus.cfg_stop_k = 32'd30; bus.cfg_step_k = 32'd10;
    bus.cfg_dwell = 16'd0; bus.cfg_phase = 11'd3; bus.cfg_repeat = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus.abort = (c == 7);
      @(negedge clk);
      cur_c = c;
      if (c <= 7) begin
        chk("k_out",    bus.k_out,    10 + 10 * ((c - 1) % 3));
        chk("k_valid",  bus.k_valid,  1);
        chk("busy",     bus.busy,     1);
        chk("step_idx", bus.step_idx, (c - 1) % 3);
      end else begin
        chk("k_out",    bus.k_out,    10);
        chk("k_valid",  bus.k_valid,  0);
        chk("busy",     bus.busy,     0);
        chk("p_out",    bus.p_out,    3);
      end
      chk("done", bus.done, 0);
    end
    bus.abort = 1'b0;
    bus.cfg_repeat = 1'b0;
    $display("sweep repeat_abort: 10..30 step 10 repeating, aborted in cycle 7");

    // start and abort together in IDLE
    cur_tag = "start_abort_idle";
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      cur_c = c;
      chk("busy", bus.busy, 0);
      chk("k_valid", bus.k_valid, 0);
      chk("k_out", bus.k_out, 10);
    end
    $display("sweep start_abort_idle: request ignored");

    // Reset asserted mid-sweep
    cur_tag = "reset_mid";
    @(posedge clk); #1;
    bus.cfg_start_k = 32'd100; bus.cfg_stop_k = 32'd130; bus.cfg_step_k = 32'd10;
    bus.cfg_dwell = 16'd2; bus.cfg_phase = 11'h55; bus.cfg_repeat = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      rst = (c == 4);
      @(negedge clk);
      cur_c = c;
      if (c == 4) begin
        chk("k_out", bus.k_out, 110);
        chk("busy", bus.busy, 1);
      end else if (c == 5) begin
        chk("k_out", bus.k_out, 0);       chk("p_out", bus.p_out, 0);
        chk("busy", bus.busy, 0);         chk("step_idx", bus.step_idx, 0);
        chk("k_valid", bus.k_valid, 0);   chk("done", bus.done, 0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("sweep reset_mid: reset in cycle 4");

    // Random sweeps against the point-list model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        1:       rs = 32'($urandom_range(0, 255));
        default: rs = $urandom;
      endcase
      span = $urandom_range(0, 400);
      el = ($urandom_range(0, 1) == 1) ? longint'(rs) + longint'(span)
                                       : longint'(rs) - longint'(span);
      if (el < 0) el = 0;
      if (el > 64'h0000_0000_FFFF_FFFF) el = 64'h0000_0000_FFFF_FFFF;
      re = el[31:0];
      rst_k = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(5, 150));
      rd = $urandom_range(0, 3);
      build_points(rs, re, rst_k);
      exp_done = exp_q.size() * (rd + 1) + 1;
      run_sweep($sformatf("rnd%0d", i), rs, re, rst_k, rd, 11'($urandom_range(0, 2047)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer that drives the frequency control word and phase offset of the DDS phase-accumulator datapath. It steps the DDS linearly from a start word to a stop word, holding each frequency for a programmable dwell. It supports single or repeating sweeps and uses a start/busy/done handshake toward the host-side control logic. The block sits directly upstream of the DDS wave generator; its `k_out`/`p_out` feed the generator's K/P inputs.

## Interface
- `DWELL_W`, 16: width of dwell count.
- `IDX_W`, 16: width of step index output.
- `clk` in 1: system clock. One clock domain; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: sweep request. Sampled only in IDLE.
- `abort` in 1: terminate sweep. Any state.
- `cfg_start_k` in 32: first frequency word.
- `cfg_stop_k` in 32: last frequency word.
- `cfg_step_k` in 32: unsigned step magnitude.
- `cfg_dwell` in DWELL_W: each point is held for `cfg_dwell`+1 cycles.
- `cfg_phase` in 11: phase offset applied for the whole sweep.
- `cfg_repeat` in 1: 1 restarts from start word after the last point.
- `k_out` out 32: frequency word to DDS.
- `p_out` out 11: phase word to DDS.
- `k_valid` out 1: one-cycle pulse when `k_out` is updated.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `step_idx` out IDX_W: index of the current point; saturates at all-ones.

## Operation
- Reset values: state IDLE; `k_out`=0, `p_out`=0, `k_valid`=0, `busy`=0, `done`=0, `step_idx`=0, dwell counter 0.
- States: IDLE, RUN.
- IDLE with `start`=1 and `abort`=0:
  - Latch all `cfg_*` into shadow registers.
  - `k_out`<=start, `p_out`<=phase, `k_valid`<=1, `busy`<=1, `step_idx`<=0, counter<=dwell.
  - Go to RUN.
- Direction is fixed at latch time: up if stop >= start, else down.
- RUN, counter != 0: decrement the counter; outputs hold.
- RUN, counter == 0, `k_out` != stop:
  - `k_out`<=next, `k_valid`<=1, `step_idx`++, counter<=dwell.
  - next = `k_out` ± step, computed in 33 bits.
  - If next passes stop, or wraps past 0 or 2^32-1, next is clamped to stop.
- RUN, counter == 0, `k_out` == stop:
  - `cfg_repeat`=1: reload the start word (same actions as the start transition); no `done`.
  - `cfg_repeat`=0: `done`<=1 for one cycle, `busy`<=0, go to IDLE. `k_out` and `p_out` hold their last value.
- `cfg_step_k`=0: the sweep is a single point at the start word.
  - With repeat, start is re-issued every dwell+1 cycles until abort.
  - Without repeat, `done` follows after one dwell.
- start == stop: single point; same behaviour as step 0.
- `abort` in RUN: next cycle IDLE, `busy`=0, no `done`, no `k_valid`; `k_out`/`p_out` hold.
- `abort` and `start` in the same cycle: abort wins, stays IDLE.
- `start` while RUN: ignored. `cfg_*` changes while RUN: ignored until the next start.
- `rst` mid-sweep: all outputs return to reset values on the next edge, including `k_out`=0.

## Timing
- Start latency: `start` high in cycle 0 → `k_out`/`k_valid`/`busy` valid in cycle 1.
- Each point occupies exactly dwell+1 cycles. `k_valid` is asserted in the first cycle of each point.
- N-point sweep without repeat: `done` is high in cycle N·(dwell+1)+1, together with `busy` low.
- The earliest next `start` is accepted in the `done` cycle, because the state is already IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Next-word add/compare/clamp completes in one cycle.

## Structure
- Shared package `dds_pkg`:
  - `K_W`=32 and `P_W`=11, shared with the wave generator.
  - State enum `sweep_state_t` {IDLE, RUN}.
- Sub-module `dds_step_calc`: combinational. Inputs current word, step, stop, direction. Outputs clamped next word and `at_stop` flag.
- The top level holds the FSM, shadow registers, dwell counter and output registers.

## Test plan
- start=100, stop=130, step=10, dwell=2, repeat=0 → `k_out` 100,110,120,130, 3 cycles each from cycle 1; 4 `k_valid` pulses; `done` in cycle 13; `step_idx` ends at 3.
- start=0, stop=25, step=10, dwell=0 → 0,10,20,25 on consecutive cycles (clamp); `done` in cycle 5.
- start=50, stop=20, step=15, dwell=1 → 50,35,20 (down sweep); start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 → 0xFFFFFFF0 then 0xFFFFFFFF (overflow clamp, no wrap).
- start=10, stop=30, step=10, dwell=0, repeat=1 → 10,20,30,10,20,… with no `done`; `abort` in cycle 7 → `busy`=0 in cycle 8, `k_out` holds, no `done`.
- Mid-sweep, change `cfg_stop_k` and pulse `start` → no effect on the sequence. `start`+`abort` in the same IDLE cycle → remains IDLE.
- `rst` asserted during RUN → next cycle `k_out`=0, `p_out`=0, `busy`=0, `step_idx`=0. step=0, repeat=0, dwell=3 → single point, `done` in cycle 5.
